// File: rtl/bias_bank_sel_seq_if.sv
// Load/request/result bundle between the bias-loading controller (master) and
// bias_bank_sel_seq (slave).
interface bias_bank_sel_seq_if #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned BIAS_W       = 18,
  parameter int unsigned N_BANKS      = 8
);
  localparam int unsigned SEL_W = $clog2(N_BANKS);
  localparam int unsigned VEC_W = N_adder_tree * BIAS_W;

  logic             ld_en;
  logic [SEL_W-1:0] ld_addr;
  logic [VEC_W-1:0] ld_data;
  logic             seq_mode;
  logic             sel_valid;
  logic [SEL_W-1:0] sel;
  logic             seq_clr;
  logic [VEC_W-1:0] BIAS;
  logic             bias_valid;
  logic             sel_err;
  logic [SEL_W-1:0] cur_bank;

  modport master (
    output ld_en, ld_addr, ld_data, seq_mode, sel_valid, sel, seq_clr,
    input  BIAS, bias_valid, sel_err, cur_bank
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, seq_mode, sel_valid, sel, seq_clr,
    output BIAS, bias_valid, sel_err, cur_bank
  );
endinterface

// File: rtl/bias_bank_sel_seq.sv
// Banked bias-vector store with explicit or sequential selection and a registered,
// valid-qualified output. Define BIAS_BANK_OUT_PIPE_EN for a second output stage.
module bias_bank_sel_seq #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned BIAS_W       = 18,
  parameter int unsigned N_BANKS      = 8,
  localparam int unsigned SEL_W       = $clog2(N_BANKS)
) (
  input logic                clk,
  input logic                rst,
  bias_bank_sel_seq_if.slave bus
);

  localparam int unsigned VEC_W = N_adder_tree * BIAS_W;

  logic [VEC_W-1:0]   bank_q [N_BANKS];
  logic [N_BANKS-1:0] loaded_q, loaded_d;
  logic [SEL_W-1:0]   cnt_q, cnt_d;

  logic               ld_in_range;
  logic               ld_we;
  logic [SEL_W-1:0]   idx;
  logic               idx_in_range;
  logic [VEC_W-1:0]   rd_data;
  logic               rd_loaded;
  logic               wr_through;
  logic               hit;

  // Stage 1 output register
  logic               s1_valid_q, s1_valid_d;
  logic [VEC_W-1:0]   s1_bias_q, s1_bias_d;
  logic               s1_err_q, s1_err_d;
  logic [SEL_W-1:0]   s1_bank_q, s1_bank_d;

  // Widened by one bit so N_BANKS == 2**SEL_W still compares correctly.
  assign ld_in_range  = {1'b0, bus.ld_addr} < (SEL_W + 1)'(N_BANKS);
  assign ld_we        = bus.ld_en && ld_in_range && !rst;
  assign idx          = bus.seq_mode ? cnt_q : bus.sel;
  assign idx_in_range = {1'b0, idx} < (SEL_W + 1)'(N_BANKS);

  always_comb begin
    rd_data   = '0;
    rd_loaded = 1'b0;
    for (int b = 0; b < int'(N_BANKS); b++) begin
      if (idx == SEL_W'(b)) begin
        rd_data   = bank_q[b];
        rd_loaded = loaded_q[b];
      end
    end
  end

  // A load to the requested bank in the same cycle is forwarded to the output.
  assign wr_through = ld_we && (bus.ld_addr == idx);
  assign hit        = wr_through || (idx_in_range && rd_loaded);

  always_comb begin
    loaded_d = loaded_q;
    if (ld_we) begin
      for (int b = 0; b < int'(N_BANKS); b++) begin
        if (bus.ld_addr == SEL_W'(b)) loaded_d[b] = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.seq_clr) begin
      cnt_d = '0;
    end else if (bus.seq_mode && bus.sel_valid) begin
      cnt_d = (cnt_q == SEL_W'(N_BANKS - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    s1_valid_d = bus.sel_valid;
    s1_bias_d  = s1_bias_q;
    s1_err_d   = s1_err_q;
    s1_bank_d  = s1_bank_q;
    if (bus.sel_valid) begin
      s1_bank_d = idx;
      s1_err_d  = !hit;
      if (wr_through) begin
        s1_bias_d = bus.ld_data;
      end else if (hit) begin
        s1_bias_d = rd_data;
      end else begin
        s1_bias_d = '0;
      end
    end
  end

  // Bank contents deliberately survive reset; only the loaded flags are cleared.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(N_BANKS); b++) begin
      if (ld_we && (bus.ld_addr == SEL_W'(b))) bank_q[b] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q   <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_bias_q  <= '0;
      s1_err_q   <= 1'b0;
      s1_bank_q  <= '0;
    end else begin
      loaded_q   <= loaded_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_bias_q  <= s1_bias_d;
      s1_err_q   <= s1_err_d;
      s1_bank_q  <= s1_bank_d;
    end
  end

`ifdef BIAS_BANK_OUT_PIPE_EN
  logic             s2_valid_q;
  logic [VEC_W-1:0] s2_bias_q;
  logic             s2_err_q;
  logic [SEL_W-1:0] s2_bank_q;

  // Stage 1 already holds on idle cycles, so a plain copy preserves hold semantics.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_bias_q  <= '0;
      s2_err_q   <= 1'b0;
      s2_bank_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_bias_q  <= s1_bias_q;
      s2_err_q   <= s1_err_q;
      s2_bank_q  <= s1_bank_q;
    end
  end

  assign bus.bias_valid = s2_valid_q;
  assign bus.BIAS       = s2_bias_q;
  assign bus.sel_err    = s2_err_q;
  assign bus.cur_bank   = s2_bank_q;
`else
  assign bus.bias_valid = s1_valid_q;
  assign bus.BIAS       = s1_bias_q;
  assign bus.sel_err    = s1_err_q;
  assign bus.cur_bank   = s1_bank_q;
`endif

endmodule

// File: doc/bias_bank_sel_seq.md
Name: bias_bank_sel_seq

Overview:
- Parametrised successor to the fixed 8-way bias selector used in the L10–L17 layers.
- Holds N_BANKS bias vectors of N_adder_tree lanes x BIAS_W bits in internal registers. Banks are loaded one vector per cycle.
- Delivers the selected vector on a registered, valid-qualified output. Selection is either explicit (index) or sequential (internal wrap-around counter).
- Sits between the bias-loading controller and the adder-tree accumulate stage of each layer.

Parameters:
- N_adder_tree, 16, lanes per bias vector.
- BIAS_W, 18, bits per lane.
- N_BANKS, 8, number of stored bias vectors (2..64, need not be a power of two).
- SEL_W, $clog2(N_BANKS), width of bank index (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- ld_en  in  1  write ld_data into bank ld_addr this cycle.
- ld_addr  in  SEL_W  target bank for load.
- ld_data  in  N_adder_tree*BIAS_W  bias vector to store.
- seq_mode  in  1  0: use sel; 1: use internal counter.
- sel_valid  in  1  request one output vector.
- sel  in  SEL_W  explicit bank index (seq_mode=0).
- seq_clr  in  1  reset sequence counter to 0.
- BIAS  out  N_adder_tree*BIAS_W  selected bias vector, registered.
- bias_valid  out  1  BIAS valid this cycle.
- sel_err  out  1  last request hit an unloaded or out-of-range bank.
- cur_bank  out  SEL_W  bank index used by the last accepted request.

Behaviour:
- Reset (rst=1 at a clk edge):
  - BIAS=0, bias_valid=0, sel_err=0, cur_bank=0.
  - Sequence counter=0; all per-bank loaded flags cleared.
  - Bank contents are not cleared.
  - rst overrides all other inputs in that cycle. A request in flight at reset is dropped (bias_valid=0 next cycle).
- Load:
  - ld_en=1 with ld_addr<N_BANKS writes the bank and sets its loaded flag at the edge.
  - ld_addr>=N_BANKS: ignored, no flag change.
- Request index:
  - idx = sel when seq_mode=0; idx = counter when seq_mode=1.
- Latency: 1 cycle. sel_valid=1 at edge k produces bias_valid=1 after edge k+1 with:
  - BIAS = bank[idx], cur_bank = idx, sel_err = 0, when idx<N_BANKS and bank idx is loaded.
  - Otherwise: BIAS = 0, sel_err = 1, cur_bank = idx truncated to SEL_W.
- When sel_valid=0: bias_valid=0 next cycle; BIAS, sel_err and cur_bank hold their values.
- Write-through: ld_en and sel_valid in the same cycle with ld_addr==idx returns ld_data and treats the bank as loaded (sel_err=0).
- Counter:
  - Advances only on accepted requests with seq_mode=1 (sel_valid=1): N_BANKS-1 wraps to 0.
  - seq_clr=1 forces 0 at the edge and takes priority over advance. The request in that same cycle still uses the pre-clear value.
  - Holds when seq_mode=0.
- Back-to-back requests every cycle are supported (throughput 1/cycle); no backpressure.

Optional Feature:
- Macro BIAS_BANK_OUT_PIPE_EN.
- Defined: adds a second output register stage. BIAS, bias_valid, sel_err and cur_bank all appear 2 cycles after the request. rst clears both stages. Throughput stays 1/cycle.
- Undefined: latency exactly 1 cycle as above.

Test Plan:
- Reset, then load banks 0..7 with lane0 = 0x100+bank (others 0), explicit sel=3, sel_valid for 1 cycle -> next cycle bias_valid=1, lane0=0x103, cur_bank=3, sel_err=0; following cycle bias_valid=0 and BIAS held.
- seq_mode=1, sel_valid high for 10 consecutive cycles -> outputs banks 0,1,…,7,0,1 in order. Assert seq_clr at cycle 5 -> that cycle outputs bank 5, next outputs bank 0.
- Reset, load only bank 2, request sel=5 -> BIAS=0, sel_err=1, bias_valid=1. With N_BANKS=6, sel=7 -> sel_err=1, BIAS=0.
- Same-cycle ld_en=1, ld_addr=4, ld_data lane0=0x2AB with sel=4 request on an unloaded bank -> next cycle lane0=0x2AB, sel_err=0.
- Assert rst during a streaming run -> next cycle bias_valid=0, BIAS=0, counter=0, previously loaded banks report sel_err=1 until reloaded.
- With BIAS_BANK_OUT_PIPE_EN defined, repeat the first scenario -> bias_valid rises exactly 2 cycles after the request with lane0=0x103.
